axi_rd_arbiter: RTL and testbench

Two-master, one-slave AXI4-Lite read-channel arbiter that shares the single `axi_sram` instance between the instruction fetch unit (master 0) and the load/store unit (master 1). It sits between `ifu`/`lsu` and `axi_sram`. It grants one read transaction at a time, forwards the AR handshake, then routes the R beat back to the granted master. Writes do not pass through this block.

---
 rtl/axi_arb_pkg.sv | 18 +
 rtl/arb_pick2.sv | 31 +++
 rtl/axi_rd_arbiter.sv | 118 +++++++++++
 tb/tb_axi_rd_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// rtl/axi_arb_pkg.sv - shared types and constants for the two-master AXI4-Lite read arbiter
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  localparam logic M_IFU = 1'b0;
  localparam logic M_LSU = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/arb_pick2.sv
// rtl/arb_pick2.sv - two-way winner select; ARB_ROUND_ROBIN_EN gives round-robin, else m1 fixed priority
module arb_pick2
  import axi_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       winner
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    winner = M_IFU;
    if (req == 2'b11) begin
      winner = ~last_grant;
    end else if (req[1]) begin
      winner = M_LSU;
    end
  end
`else
  logic last_grant_unused;
  assign last_grant_unused = last_grant;

  always_comb begin
    winner = M_IFU;
    if (req[1]) begin
      winner = M_LSU;
    end
  end
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - IFU/LSU read arbiter in front of one AXI4-Lite slave; ARB_ROUND_ROBIN_EN picks arbitration mode
module axi_rd_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rvalid,
  output logic              s_rready,
  output logic              busy
);

  arb_state_e state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_grant_q, last_grant_d;
  logic       winner;

  arb_pick2 u_pick (
    .req        ({m1_arvalid, m0_arvalid}),
    .last_grant (last_grant_q),
    .winner     (winner)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= M_IFU;
      last_grant_q <= M_LSU;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Outputs are pure pass-through of the granted master; everything else is held at 0.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    m0_arready   = 1'b0;
    m1_arready   = 1'b0;
    m0_rdata     = '0;
    m1_rdata     = '0;
    m0_rresp     = RESP_OKAY;
    m1_rresp     = RESP_OKAY;
    m0_rvalid    = 1'b0;
    m1_rvalid    = 1'b0;
    s_araddr     = '0;
    s_arvalid    = 1'b0;
    s_rready     = 1'b0;

    case (state_q)
      IDLE: begin
        if (m0_arvalid || m1_arvalid) begin
          grant_d = winner;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (grant_q == M_LSU) begin
          s_araddr   = m1_araddr;
          s_arvalid  = m1_arvalid;
          m1_arready = s_arready;
        end else begin
          s_araddr   = m0_araddr;
          s_arvalid  = m0_arvalid;
          m0_arready = s_arready;
        end
        if (s_arvalid && s_arready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (grant_q == M_LSU) begin
          m1_rdata  = s_rdata;
          m1_rresp  = s_rresp;
          m1_rvalid = s_rvalid;
          s_rready  = m1_rready;
        end else begin
          m0_rdata  = s_rdata;
          m0_rresp  = s_rresp;
          m0_rvalid = s_rvalid;
          s_rready  = m0_rready;
        end
        if (s_rvalid && s_rready) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - scoreboard bench for axi_rd_arbiter; tie order follows ARB_ROUND_ROBIN_EN
module tb_axi_rd_arbiter;

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] m0_araddr = '0, m1_araddr = '0;
  logic        m0_arvalid = 1'b0, m1_arvalid = 1'b0;
  logic        m0_arready, m1_arready;
  logic [31:0] m0_rdata, m1_rdata;
  logic [1:0]  m0_rresp, m1_rresp;
  logic        m0_rvalid, m1_rvalid;
  logic        m0_rready = 1'b1, m1_rready = 1'b1;
  logic [31:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready = 1'b1;
  logic [31:0] s_rdata = '0;
  logic [1:0]  s_rresp = '0;
  logic        s_rvalid = 1'b0;
  logic        s_rready;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  exp_t        exp_q[$];
  logic [31:0] m0_q[$];
  logic [31:0] m1_q[$];
  logic [1:0]  slv_resp = 2'b00;

  logic        rst_s = 1'b0;
  logic        m0_fire_s = 1'b0, m1_fire_s = 1'b0;
  logic        ar_fire_s = 1'b0, r_fire_s = 1'b0;
  logic [31:0] ar_addr_s = '0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;

  axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .m0_araddr  (m0_araddr),
    .m0_arvalid (m0_arvalid),
    .m0_arready (m0_arready),
    .m0_rdata   (m0_rdata),
    .m0_rresp   (m0_rresp),
    .m0_rvalid  (m0_rvalid),
    .m0_rready  (m0_rready),
    .m1_araddr  (m1_araddr),
    .m1_arvalid (m1_arvalid),
    .m1_arready (m1_arready),
    .m1_rdata   (m1_rdata),
    .m1_rresp   (m1_rresp),
    .m1_rvalid  (m1_rvalid),
    .m1_rready  (m1_rready),
    .s_araddr   (s_araddr),
    .s_arvalid  (s_arvalid),
    .s_arready  (s_arready),
    .s_rdata    (s_rdata),
    .s_rresp    (s_rresp),
    .s_rvalid   (s_rvalid),
    .s_rready   (s_rready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] addr);
    if (addr == 32'h8000_0000) return 32'h0000_0413;
    return {addr[15:0], ~addr[31:16]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic req(input logic id, input logic [31:0] addr);
    if (id) m1_q.push_back(addr);
    else    m0_q.push_back(addr);
  endtask

  task automatic expect_beat(input logic id, input logic [31:0] addr, input logic [1:0] resp);
    exp_t e;
    e.id   = id;
    e.data = mem_f(addr);
    e.resp = resp;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || m0_q.size() != 0 || m1_q.size() != 0 ||
            m0_arvalid || m1_arvalid || busy) && n < 100) begin
      step();
      n++;
    end
    chk(tag, 64'(n < 100), 64'd1);
  endtask

  task automatic check_beat(input logic id, input logic [31:0] data, input logic [1:0] resp,
                            input logic other_valid, input logic [31:0] other_data,
                            input logic [1:0] other_resp);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_beat", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk("beat_master", 64'(id), 64'(e.id));
      chk("beat_rdata", 64'(data), 64'(e.data));
      chk("beat_rresp", 64'(resp), 64'(e.resp));
      chk("other_rvalid", 64'(other_valid), 64'd0);
      chk("other_rdata", {30'd0, other_resp, other_data}, 64'd0);
    end
  endtask

  // Edge-stable sampling of handshakes for the models and the scoreboard.
  always @(negedge clk) begin
    rst_s     = rst;
    m0_fire_s = m0_arvalid && m0_arready;
    m1_fire_s = m1_arvalid && m1_arready;
    ar_fire_s = s_arvalid && s_arready;
    r_fire_s  = s_rvalid && s_rready;
    ar_addr_s = s_araddr;
    if (rst) begin
      chk("arready_excl", 64'(m0_arready && m1_arready), 64'd0);
      if (m0_rvalid && m0_rready) check_beat(1'b0, m0_rdata, m0_rresp, m1_rvalid, m1_rdata, m1_rresp);
      if (m1_rvalid && m1_rready) check_beat(1'b1, m1_rdata, m1_rresp, m0_rvalid, m0_rdata, m0_rresp);
    end
  end

  // Masters: hold arvalid until accepted, then load the next queued address.
  always @(posedge clk) begin
    #1;
    if (!rst_s) begin
      m0_arvalid = 1'b0;
      m1_arvalid = 1'b0;
    end else begin
      if (m0_fire_s) m0_arvalid = 1'b0;
      if (m1_fire_s) m1_arvalid = 1'b0;
      if (!m0_arvalid && m0_q.size() != 0) begin
        m0_araddr  = m0_q.pop_front();
        m0_arvalid = 1'b1;
      end
      if (!m1_arvalid && m1_q.size() != 0) begin
        m1_araddr  = m1_q.pop_front();
        m1_arvalid = 1'b1;
      end
    end
  end

  // Slave: one beat per accepted address, earliest on the cycle after the AR handshake.
  always @(posedge clk) begin
    #1;
    if (!rst_s) begin
      s_rvalid = 1'b0;
      s_rdata  = '0;
      s_rresp  = '0;
      pend     = 1'b0;
    end else begin
      if (r_fire_s) s_rvalid = 1'b0;
      if (ar_fire_s) begin
        pend      = 1'b1;
        pend_addr = ar_addr_s;
      end
      if (pend && !s_rvalid) begin
        s_rvalid = 1'b1;
        s_rdata  = mem_f(pend_addr);
        s_rresp  = slv_resp;
        pend     = 1'b0;
      end
    end
  end

  initial begin
    int busy_cnt;
    int n;

    rst = 1'b0;
    repeat (3) step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_s_arvalid", 64'(s_arvalid), 64'd0);
    chk("rst_s_araddr", 64'(s_araddr), 64'd0);
    chk("rst_s_rready", 64'(s_rready), 64'd0);
    chk("rst_arready", {62'd0, m1_arready, m0_arready}, 64'd0);
    chk("rst_rvalid", {62'd0, m1_rvalid, m0_rvalid}, 64'd0);
    rst = 1'b1;
    step();

    // Simultaneous requests straight after reset.
`ifdef ARB_ROUND_ROBIN_EN
    expect_beat(1'b0, 32'h8000_0004, 2'b00);
    expect_beat(1'b1, 32'h8000_1000, 2'b00);
    expect_beat(1'b1, 32'h8000_1004, 2'b00);
`else
    expect_beat(1'b1, 32'h8000_1000, 2'b00);
    expect_beat(1'b1, 32'h8000_1004, 2'b00);
    expect_beat(1'b0, 32'h8000_0004, 2'b00);
`endif
    req(1'b0, 32'h8000_0004);
    req(1'b1, 32'h8000_1000);
    req(1'b1, 32'h8000_1004);
    drain("tie_drain");

    // Single IFU read with a zero-wait slave.
    step();
    expect_beat(1'b0, 32'h8000_0000, 2'b00);
    req(1'b0, 32'h8000_0000);
    busy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (busy) busy_cnt++;
      chk("single_m1_rvalid", 64'(m1_rvalid), 64'd0);
    end
    chk("single_busy_cycles", 64'(busy_cnt), 64'd2);
    chk("single_done", 64'(exp_q.size()), 64'd0);

    // Backpressure on AR then on R.
    s_arready = 1'b0;
    m0_rready = 1'b0;
    expect_beat(1'b0, 32'h8000_0008, 2'b00);
    req(1'b0, 32'h8000_0008);
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_addr_busy", 64'(busy), 64'd1);
      chk("bp_addr_s_arvalid", 64'(s_arvalid), 64'd1);
      chk("bp_addr_s_araddr", 64'(s_araddr), 64'h8000_0008);
      chk("bp_addr_m0_arready", 64'(m0_arready), 64'd0);
    end
    s_arready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("bp_data_m0_rvalid", 64'(m0_rvalid), 64'd1);
      chk("bp_data_m0_rdata", 64'(m0_rdata), 64'(mem_f(32'h8000_0008)));
      chk("bp_data_s_rready", 64'(s_rready), 64'd0);
      chk("bp_data_queued", 64'(exp_q.size()), 64'd1);
    end
    m0_rready = 1'b1;
    drain("bp_drain");

    // Error response forwarded to m1.
    slv_resp = 2'b10;
    expect_beat(1'b1, 32'h8000_2000, 2'b10);
    req(1'b1, 32'h8000_2000);
    drain("slverr_drain");
    chk("slverr_idle", 64'(busy), 64'd0);
    slv_resp = 2'b00;

    // Reset while the beat is held in DATA.
    m0_rready = 1'b0;
    req(1'b0, 32'h8000_000C);
    n = 0;
    while (!m0_rvalid && n < 20) begin
      step();
      n++;
    end
    chk("rstmid_reach_data", 64'(m0_rvalid), 64'd1);
    rst = 1'b0;
    step();
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_m0_rvalid", 64'(m0_rvalid), 64'd0);
    chk("rstmid_s_rready", 64'(s_rready), 64'd0);
    chk("rstmid_s_arvalid", 64'(s_arvalid), 64'd0);
    chk("rstmid_s_araddr", 64'(s_araddr), 64'd0);
    chk("rstmid_m0_rdata", 64'(m0_rdata), 64'd0);
    rst = 1'b1;
    m0_rready = 1'b1;
    step();
    expect_beat(1'b0, 32'h8000_0010, 2'b00);
    req(1'b0, 32'h8000_0010);
    drain("rstmid_after_drain");

    step();
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
